// File: rtl/ex_mdu_if.sv
// ID/EX-side bundle for the multiply/divide unit: issue fields in, stall and writeback out.
interface ex_mdu_if;
   logic        flush_i;
   logic [31:0] inst_i;
   logic [31:0] op_num1_i;
   logic [31:0] op_num2_i;
   logic [4:0]  rd_addr_i;
   logic        reg_wen_i;
   logic        hold_o;
   logic        valid_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        reg_wen_o;

   modport master (
      output flush_i, inst_i, op_num1_i, op_num2_i, rd_addr_i, reg_wen_i,
      input  hold_o, valid_o, result_o, rd_addr_o, reg_wen_o
   );

   modport slave (
      input  flush_i, inst_i, op_num1_i, op_num2_i, rd_addr_i, reg_wen_i,
      output hold_o, valid_o, result_o, rd_addr_o, reg_wen_o
   );
endinterface

// File: rtl/ex_mdu.sv
// RV32M multiply/divide unit for the EX stage: delayed combinational multiplier and a
// 32-step restoring divider, stalling ID/EX through hold_o until the result is written back.
module ex_mdu #(
   parameter int MUL_LAT  = 1,
   parameter bit DIV_FAST = 1'b1
) (
   input logic     clk,
   input logic     rst,
   ex_mdu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state;
   logic [4:0]  count;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [2:0]  funct3;
   logic [4:0]  rd_q;
   logic        wen_q;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] div_mag;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;
   logic        valid_q;
   logic [31:0] result_q;
   logic [4:0]  rd_out_q;
   logic        wen_out_q;

   logic        is_m;
   logic [2:0]  f3_in;
   logic        div_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        zero_in;
   logic        ovf_in;
   logic [31:0] fast_res;

   assign is_m       = (bus.inst_i[6:0] == 7'b0110011) && (bus.inst_i[31:25] == 7'b0000001);
   assign f3_in      = bus.inst_i[14:12];
   assign div_signed = ~f3_in[0];
   assign a_neg      = div_signed & bus.op_num1_i[31];
   assign b_neg      = div_signed & bus.op_num2_i[31];
   assign a_mag      = a_neg ? (~bus.op_num1_i + 32'd1) : bus.op_num1_i;
   assign b_mag      = b_neg ? (~bus.op_num2_i + 32'd1) : bus.op_num2_i;
   assign zero_in    = (bus.op_num2_i == 32'd0);
   assign ovf_in     = div_signed && (bus.op_num1_i == 32'h8000_0000) &&
                       (bus.op_num2_i == 32'hFFFF_FFFF);
   assign fast_res   = zero_in ? (f3_in[1] ? bus.op_num1_i : 32'hFFFF_FFFF)
                               : (f3_in[1] ? 32'd0 : 32'h8000_0000);

   // Operands are extended to 66 bits so one unsigned multiply covers every signedness mix
   logic        mul_a_sgn;
   logic        mul_b_sgn;
   logic [65:0] mul_a;
   logic [65:0] mul_b;
   logic [65:0] prod;
   logic [31:0] mul_res;

   assign mul_a_sgn = (funct3 == 3'd1) || (funct3 == 3'd2);
   assign mul_b_sgn = (funct3 == 3'd1);
   assign mul_a     = {{34{mul_a_sgn & op_a[31]}}, op_a};
   assign mul_b     = {{34{mul_b_sgn & op_b[31]}}, op_b};
   assign prod      = mul_a * mul_b;
   assign mul_res   = (funct3 == 3'd0) ? prod[31:0] : prod[63:32];

   logic [32:0] rem_shift;
   logic [32:0] diff;
   logic        take;
   logic [31:0] rem_next;
   logic [31:0] quot_next;
   logic [31:0] q_res;
   logic [31:0] r_res;
   logic [31:0] div_res;

   assign rem_shift = {rem, quot[31]};
   assign diff      = rem_shift - {1'b0, div_mag};
   assign take      = ~diff[32];
   assign rem_next  = take ? diff[31:0] : rem_shift[31:0];
   assign quot_next = {quot[30:0], take};
   // A zero divisor leaves an all-ones quotient that must not be negated
   assign q_res     = div_zero ? 32'hFFFF_FFFF : (neg_q ? (~quot_next + 32'd1) : quot_next);
   assign r_res     = neg_r ? (~rem_next + 32'd1) : rem_next;
   assign div_res   = funct3[1] ? r_res : q_res;

   assign bus.hold_o    = ~bus.flush_i &
                          (((state == IDLE) && is_m) || (state == MUL) || (state == DIV));
   assign bus.valid_o   = valid_q;
   assign bus.result_o  = result_q;
   assign bus.rd_addr_o = rd_out_q;
   assign bus.reg_wen_o = wen_out_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         funct3    <= '0;
         rd_q      <= '0;
         wen_q     <= 1'b0;
         quot      <= '0;
         rem       <= '0;
         div_mag   <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div_zero  <= 1'b0;
         valid_q   <= 1'b0;
         result_q  <= '0;
         rd_out_q  <= '0;
         wen_out_q <= 1'b0;
      end else if (bus.flush_i) begin
         state     <= IDLE;
         count     <= '0;
         valid_q   <= 1'b0;
         wen_out_q <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         wen_out_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (is_m) begin
                  op_a     <= bus.op_num1_i;
                  op_b     <= bus.op_num2_i;
                  funct3   <= f3_in;
                  rd_q     <= bus.rd_addr_i;
                  wen_q    <= bus.reg_wen_i;
                  count    <= '0;
                  quot     <= a_mag;
                  rem      <= '0;
                  div_mag  <= b_mag;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div_zero <= zero_in;
                  if (!f3_in[2]) begin
                     state <= MUL;
                  end else if (DIV_FAST && (zero_in || ovf_in)) begin
                     state     <= DONE;
                     valid_q   <= 1'b1;
                     wen_out_q <= bus.reg_wen_i;
                     result_q  <= fast_res;
                     rd_out_q  <= bus.rd_addr_i;
                  end else begin
                     state <= DIV;
                  end
               end
            end
            MUL: begin
               if (count == 5'(MUL_LAT - 1)) begin
                  state     <= DONE;
                  valid_q   <= 1'b1;
                  wen_out_q <= wen_q;
                  result_q  <= mul_res;
                  rd_out_q  <= rd_q;
               end else begin
                  count <= count + 5'd1;
               end
            end
            DIV: begin
               quot <= quot_next;
               rem  <= rem_next;
               if (count == 5'd31) begin
                  state     <= DONE;
                  valid_q   <= 1'b1;
                  wen_out_q <= wen_q;
                  result_q  <= div_res;
                  rd_out_q  <= rd_q;
               end else begin
                  count <= count + 5'd1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
